// File: rtl/plugin_arbiter.sv
// Arbiter sharing one multi-cycle plugin execution unit between the core execute
// stage and the MMIO plugin window, with one-deep request buffers and a timeout watchdog.
module plugin_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  core_req_i,
    input  logic [DATA_WIDTH-1:0] core_op_a_i,
    input  logic [DATA_WIDTH-1:0] core_op_b_i,
    output logic                  core_ready_o,
    output logic                  core_done_o,
    output logic                  core_error_o,
    output logic [DATA_WIDTH-1:0] core_result_o,
    input  logic                  mmio_req_i,
    input  logic [DATA_WIDTH-1:0] mmio_op_a_i,
    input  logic [DATA_WIDTH-1:0] mmio_op_b_i,
    output logic                  mmio_ready_o,
    output logic                  mmio_done_o,
    output logic                  mmio_error_o,
    output logic [DATA_WIDTH-1:0] mmio_result_o,
    output logic                  plugin_start_o,
    output logic [DATA_WIDTH-1:0] plugin_op_a_o,
    output logic [DATA_WIDTH-1:0] plugin_op_b_o,
    input  logic                  plugin_busy_i,
    input  logic                  plugin_done_i,
    input  logic [DATA_WIDTH-1:0] plugin_result_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic                  OWN_CORE  = 1'b0;
    localparam logic                  OWN_MMIO  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_r, state_next_s;
    logic                  core_pend_r, mmio_pend_r;
    logic [DATA_WIDTH-1:0] core_a_r, core_b_r, mmio_a_r, mmio_b_r;
    logic                  owner_r, last_owner_r, grant_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [DATA_WIDTH-1:0] op_a_r, op_b_r, core_result_r, mmio_result_r;
    logic                  err_r;
    logic                  core_accept_s, mmio_accept_s;

    assign core_accept_s = core_req_i && core_ready_o;
    assign mmio_accept_s = mmio_req_i && mmio_ready_o;
    assign core_result_o = core_result_r;
    assign mmio_result_o = mmio_result_r;
    assign plugin_op_a_o = op_a_r;
    assign plugin_op_b_o = op_b_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a simultaneous done beats the timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:  state_next_s = (core_pend_r || mmio_pend_r) ? S_ISSUE : S_IDLE;
            S_ISSUE: state_next_s = plugin_busy_i ? S_ISSUE : S_WAIT;
            S_WAIT:  state_next_s = (plugin_done_i || (cnt_r == CNT_LAST)) ? S_RESP : S_WAIT;
            S_RESP:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Round-robin pick: on a tie the requester that was not served last wins.
    always_comb begin
        grant_s = OWN_CORE;
        if (core_pend_r && mmio_pend_r) begin
            grant_s = ~last_owner_r;
        end else if (mmio_pend_r) begin
            grant_s = OWN_MMIO;
        end else begin
            grant_s = OWN_CORE;
        end
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        plugin_start_o = (state_r == S_ISSUE) && !plugin_busy_i;
        core_done_o    = (state_r == S_RESP) && (owner_r == OWN_CORE);
        mmio_done_o    = (state_r == S_RESP) && (owner_r == OWN_MMIO);
        core_error_o   = core_done_o && err_r;
        mmio_error_o   = mmio_done_o && err_r;
        core_ready_o   = !core_pend_r && !((owner_r == OWN_CORE) && (state_r != S_IDLE));
        mmio_ready_o   = !mmio_pend_r && !((owner_r == OWN_MMIO) && (state_r != S_IDLE));
    end

    // Request buffers, grant bookkeeping, watchdog and result capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            core_pend_r   <= 1'b0;
            mmio_pend_r   <= 1'b0;
            core_a_r      <= DATA_ZERO;
            core_b_r      <= DATA_ZERO;
            mmio_a_r      <= DATA_ZERO;
            mmio_b_r      <= DATA_ZERO;
            owner_r       <= OWN_CORE;
            last_owner_r  <= OWN_MMIO;
            cnt_r         <= CNT_ZERO;
            op_a_r        <= DATA_ZERO;
            op_b_r        <= DATA_ZERO;
            core_result_r <= DATA_ZERO;
            mmio_result_r <= DATA_ZERO;
            err_r         <= 1'b0;
        end else begin
            if (core_accept_s) begin
                core_pend_r <= 1'b1;
                core_a_r    <= core_op_a_i;
                core_b_r    <= core_op_b_i;
            end
            if (mmio_accept_s) begin
                mmio_pend_r <= 1'b1;
                mmio_a_r    <= mmio_op_a_i;
                mmio_b_r    <= mmio_op_b_i;
            end
            case (state_r)
                S_IDLE: begin
                    // Accept and grant never hit the same requester: accept needs !pending.
                    if (core_pend_r || mmio_pend_r) begin
                        owner_r <= grant_s;
                        if (grant_s == OWN_CORE) begin
                            core_pend_r <= 1'b0;
                            op_a_r      <= core_a_r;
                            op_b_r      <= core_b_r;
                        end else begin
                            mmio_pend_r <= 1'b0;
                            op_a_r      <= mmio_a_r;
                            op_b_r      <= mmio_b_r;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!plugin_busy_i) begin
                        cnt_r <= CNT_ZERO;
                    end
                end
                S_WAIT: begin
                    if (plugin_done_i || (cnt_r == CNT_LAST)) begin
                        err_r <= !plugin_done_i;
                        if (owner_r == OWN_CORE) begin
                            core_result_r <= plugin_done_i ? plugin_result_i : DATA_ZERO;
                        end else begin
                            mmio_result_r <= plugin_done_i ? plugin_result_i : DATA_ZERO;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_RESP: begin
                    last_owner_r <= owner_r;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plugin_arbiter.sv
// Self-checking bench for plugin_arbiter: directed scenarios plus a randomized
// phase scored against a transaction-level model (per-requester FIFO of a+b).
module tb_plugin_arbiter;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          core_req_i, mmio_req_i;
    logic [DW-1:0] core_op_a_i, core_op_b_i, mmio_op_a_i, mmio_op_b_i;
    logic          core_ready_o, core_done_o, core_error_o;
    logic          mmio_ready_o, mmio_done_o, mmio_error_o;
    logic [DW-1:0] core_result_o, mmio_result_o;
    logic          plugin_start_o, plugin_busy_i, plugin_done_i;
    logic [DW-1:0] plugin_op_a_o, plugin_op_b_o, plugin_result_i;

    plugin_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .core_req_i(core_req_i), .core_op_a_i(core_op_a_i), .core_op_b_i(core_op_b_i),
        .core_ready_o(core_ready_o), .core_done_o(core_done_o), .core_error_o(core_error_o),
        .core_result_o(core_result_o),
        .mmio_req_i(mmio_req_i), .mmio_op_a_i(mmio_op_a_i), .mmio_op_b_i(mmio_op_b_i),
        .mmio_ready_o(mmio_ready_o), .mmio_done_o(mmio_done_o), .mmio_error_o(mmio_error_o),
        .mmio_result_o(mmio_result_o),
        .plugin_start_o(plugin_start_o), .plugin_op_a_o(plugin_op_a_o), .plugin_op_b_o(plugin_op_b_o),
        .plugin_busy_i(plugin_busy_i), .plugin_done_i(plugin_done_i), .plugin_result_i(plugin_result_i)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0, cyc = 0;
    int ptimer = 0, pdelay = 3, busy_until = -1, inject_at = -1;
    bit silent = 1'b0, rand_busy = 1'b0, rand_mode = 1'b0;
    logic [DW-1:0] pa, pb;
    int start_cnt = 0, start_cyc = -1;
    int core_done_cnt = 0, core_done_cyc = -1, mmio_done_cnt = 0, mmio_done_cyc = -1;
    logic [DW-1:0] core_res_seen, mmio_res_seen;
    logic core_err_seen, mmio_err_seen;
    bit core_out = 1'b0, mmio_out = 1'b0, core_rdy_exp, mmio_rdy_exp;
    logic [DW-1:0] core_q[$], mmio_q[$];
    logic [DW-1:0] ra, rb;
    int e0, s0, d0, m0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: plugin model drives busy/done at +1, outputs are sampled at +2.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        plugin_done_i = 1'b0;
        if (ptimer > 0) begin
            ptimer--;
            if (ptimer == 0 && !silent) begin
                plugin_done_i   = 1'b1;
                plugin_result_i = pa + pb;
            end
        end
        if (cyc == inject_at) begin
            plugin_done_i   = 1'b1;
            plugin_result_i = 32'hdead_beef;
        end
        plugin_busy_i = (cyc <= busy_until) ? 1'b1 :
                        (rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0);
        #1;
        chk("start_while_busy", plugin_start_o && plugin_busy_i, 1'b0);
        if (rand_mode) begin
            chk("rand_core_ready", core_ready_o, !core_out);
            chk("rand_mmio_ready", mmio_ready_o, !mmio_out);
            if (ptimer > 0 && !plugin_start_o) begin
                chk("rand_op_a_stable", plugin_op_a_o, pa);
                chk("rand_op_b_stable", plugin_op_b_o, pb);
            end
        end
        if (plugin_start_o) begin
            start_cnt++;
            start_cyc = cyc;
            pa = plugin_op_a_o;
            pb = plugin_op_b_o;
            ptimer = rand_mode ? $urandom_range(1, TO) : pdelay;
        end
        core_rdy_exp = !core_out;
        mmio_rdy_exp = !mmio_out;
        if (core_done_o) begin
            core_done_cnt++;
            core_done_cyc = cyc;
            core_res_seen = core_result_o;
            core_err_seen = core_error_o;
            if (rand_mode) begin
                chk("rand_core_q_nonempty", core_q.size() != 0, 1'b1);
                if (core_q.size() != 0) chk("rand_core_result", core_result_o, core_q.pop_front());
                chk("rand_core_error", core_error_o, 1'b0);
                core_out = 1'b0;
            end
        end
        if (mmio_done_o) begin
            mmio_done_cnt++;
            mmio_done_cyc = cyc;
            mmio_res_seen = mmio_result_o;
            mmio_err_seen = mmio_error_o;
            if (rand_mode) begin
                chk("rand_mmio_q_nonempty", mmio_q.size() != 0, 1'b1);
                if (mmio_q.size() != 0) chk("rand_mmio_result", mmio_result_o, mmio_q.pop_front());
                chk("rand_mmio_error", mmio_error_o, 1'b0);
                mmio_out = 1'b0;
            end
        end
    endtask

    task automatic req_core(input logic [DW-1:0] a, input logic [DW-1:0] b);
        core_req_i = 1'b1; core_op_a_i = a; core_op_b_i = b;
        tick();
        core_req_i = 1'b0;
    endtask

    task automatic req_both(input logic [DW-1:0] ca, input logic [DW-1:0] cb,
                            input logic [DW-1:0] ma, input logic [DW-1:0] mb);
        core_req_i = 1'b1; core_op_a_i = ca; core_op_b_i = cb;
        mmio_req_i = 1'b1; mmio_op_a_i = ma; mmio_op_b_i = mb;
        tick();
        core_req_i = 1'b0; mmio_req_i = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; core_req_i = 1'b0; mmio_req_i = 1'b0;
        core_op_a_i = '0; core_op_b_i = '0; mmio_op_a_i = '0; mmio_op_b_i = '0;
        plugin_busy_i = 1'b0; plugin_done_i = 1'b0; plugin_result_i = '0;
        tick(); tick();
        reset_n = 1'b1;
        chk("rst_core_ready", core_ready_o, 1'b1);
        chk("rst_mmio_ready", mmio_ready_o, 1'b1);
        chk("rst_core_done", core_done_o, 1'b0);
        chk("rst_mmio_done", mmio_done_o, 1'b0);
        chk("rst_start", plugin_start_o, 1'b0);
        chk("rst_core_result", core_result_o, 32'd0);
        chk("rst_mmio_result", mmio_result_o, 32'd0);
        chk("rst_op_a", plugin_op_a_o, 32'd0);
        chk("rst_op_b", plugin_op_b_o, 32'd0);

        // Single core op, D=3.
        pdelay = 3; s0 = start_cnt;
        req_core(32'd5, 32'd7); e0 = cyc;
        repeat (8) tick();
        chk("t1_start_cyc", start_cyc, e0 + 1);
        chk("t1_done_cyc", core_done_cyc, e0 + 5);
        chk("t1_result", core_res_seen, 32'd12);
        chk("t1_error", core_err_seen, 1'b0);
        chk("t1_starts", start_cnt - s0, 1);
        chk("t1_mmio_done_cnt", mmio_done_cnt, 0);
        chk("t1_mmio_result", mmio_result_o, 32'd0);

        // Tie after reset: core first, then mmio; second tie after a core op goes to mmio.
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        pdelay = 2; s0 = start_cnt;
        req_both(32'd1, 32'd2, 32'd10, 32'd20); e0 = cyc;
        repeat (14) tick();
        chk("t2_core_result", core_res_seen, 32'd3);
        chk("t2_mmio_result", mmio_res_seen, 32'd30);
        chk("t2_core_done_cyc", core_done_cyc, e0 + 4);
        chk("t2_mmio_done_cyc", mmio_done_cyc, e0 + 9);
        chk("t2_starts", start_cnt - s0, 2);
        req_core(32'd100, 32'd1);
        repeat (6) tick();
        chk("t2_core_only", core_res_seen, 32'd101);
        req_both(32'd3, 32'd4, 32'd5, 32'd6); e0 = cyc;
        repeat (14) tick();
        chk("t2_tie2_mmio_cyc", mmio_done_cyc, e0 + 4);
        chk("t2_tie2_core_cyc", core_done_cyc, e0 + 9);
        chk("t2_tie2_mmio_res", mmio_res_seen, 32'd11);
        chk("t2_tie2_core_res", core_res_seen, 32'd7);

        // Busy stall longer than the timeout must not time out.
        pdelay = 2; s0 = start_cnt;
        req_core(32'd7, 32'd8); e0 = cyc; busy_until = cyc + 6;
        repeat (12) tick();
        chk("t3_start_cyc", start_cyc, e0 + 7);
        chk("t3_done_cyc", core_done_cyc, e0 + 10);
        chk("t3_result", core_res_seen, 32'd15);
        chk("t3_error", core_err_seen, 1'b0);
        chk("t3_starts", start_cnt - s0, 1);

        // Timeout: plugin never answers.
        silent = 1'b1;
        req_core(32'd9, 32'd9); e0 = cyc;
        repeat (8) tick();
        silent = 1'b0;
        chk("t4_start_cyc", start_cyc, e0 + 1);
        chk("t4_done_cyc", core_done_cyc, e0 + 6);
        chk("t4_error", core_err_seen, 1'b1);
        chk("t4_result", core_res_seen, 32'd0);
        // Done arriving on the last WAIT cycle beats the timeout.
        pdelay = 4; m0 = mmio_done_cnt;
        req_core(32'd2, 32'd3); e0 = cyc;
        repeat (8) tick();
        chk("t4b_done_cyc", core_done_cyc, e0 + 6);
        chk("t4b_result", core_res_seen, 32'd5);
        chk("t4b_error", core_err_seen, 1'b0);
        chk("t4b_mmio_quiet", mmio_done_cnt - m0, 0);

        // Backpressure: a request while not ready is dropped.
        pdelay = 3; s0 = start_cnt; d0 = core_done_cnt;
        req_core(32'd20, 32'd22); e0 = cyc;
        tick(); tick();
        chk("t5_ready_low", core_ready_o, 1'b0);
        core_req_i = 1'b1; core_op_a_i = 32'd99; core_op_b_i = 32'd99;
        tick();
        core_req_i = 1'b0;
        repeat (6) tick();
        chk("t5_result", core_res_seen, 32'd42);
        chk("t5_done_cyc", core_done_cyc, e0 + 5);
        chk("t5_done_cnt", core_done_cnt - d0, 1);
        chk("t5_starts", start_cnt - s0, 1);
        d0 = core_done_cnt; m0 = mmio_done_cnt; s0 = start_cnt;
        inject_at = cyc + 2;
        repeat (6) tick();
        chk("t5_inject_core", core_done_cnt - d0, 0);
        chk("t5_inject_mmio", mmio_done_cnt - m0, 0);
        chk("t5_inject_starts", start_cnt - s0, 0);
        chk("t5_inject_core_res", core_result_o, 32'd42);
        chk("t5_inject_mmio_res", mmio_result_o, 32'd11);
        chk("t5_ready_back", core_ready_o, 1'b1);

        // Reset in WAIT; the late plugin done must be ignored.
        pdelay = 4;
        req_core(32'd1, 32'd1); e0 = cyc;
        tick(); tick();
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        chk("t6_core_ready", core_ready_o, 1'b1);
        chk("t6_mmio_ready", mmio_ready_o, 1'b1);
        chk("t6_start", plugin_start_o, 1'b0);
        chk("t6_core_done", core_done_o, 1'b0);
        chk("t6_core_result", core_result_o, 32'd0);
        chk("t6_mmio_result", mmio_result_o, 32'd0);
        chk("t6_op_a", plugin_op_a_o, 32'd0);
        chk("t6_op_b", plugin_op_b_o, 32'd0);
        d0 = core_done_cnt; m0 = mmio_done_cnt;
        repeat (6) tick();
        chk("t6_late_done_core", core_done_cnt - d0, 0);
        chk("t6_late_done_mmio", mmio_done_cnt - m0, 0);
        pdelay = 1;
        req_core(32'd4, 32'd5); e0 = cyc;
        repeat (5) tick();
        chk("t6_new_result", core_res_seen, 32'd9);
        chk("t6_new_error", core_err_seen, 1'b0);
        chk("t6_new_done_cyc", core_done_cyc, e0 + 3);

        // Randomized traffic from both requesters against the FIFO model.
        rand_mode = 1'b1; rand_busy = 1'b1; core_out = 1'b0; mmio_out = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            core_req_i = ($urandom_range(0, 1) == 1);
            ra = $urandom(); rb = $urandom();
            core_op_a_i = ra; core_op_b_i = rb;
            if (core_req_i && core_rdy_exp) begin
                core_q.push_back(ra + rb);
                core_out = 1'b1;
            end
            mmio_req_i = ($urandom_range(0, 1) == 1);
            ra = $urandom(); rb = $urandom();
            mmio_op_a_i = ra; mmio_op_b_i = rb;
            if (mmio_req_i && mmio_rdy_exp) begin
                mmio_q.push_back(ra + rb);
                mmio_out = 1'b1;
            end
        end
        core_req_i = 1'b0; mmio_req_i = 1'b0; rand_busy = 1'b0;
        repeat (40) tick();
        chk("rand_core_drained", core_q.size(), 0);
        chk("rand_mmio_drained", mmio_q.size(), 0);
        chk("rand_core_idle", core_out, 1'b0);
        chk("rand_mmio_idle", mmio_out, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
